// File: rtl/watch_pkg.sv
// Shared definitions for the watch time chain: stage moduli, BCD digit type,
// counter action encoding and the decimal-digit sizing helper.
package watch_pkg;

    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;
    localparam int HR_MOD  = 24;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [2:0] {
        ACT_HOLD = 3'd0,
        ACT_EN   = 3'd1,
        ACT_ADJ  = 3'd2,
        ACT_CLR  = 3'd3,
        ACT_LOAD = 3'd4
    } cnt_act_t;

    // Number of decimal digits needed to print value (at least one).
    function automatic int clog10_digits(input int value);
        int v;
        int n;
        v = value;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/modn_bcd_conv.sv
// Combinational binary-to-BCD converter (shift-and-add-3), DIGITS nibbles wide.
module modn_bcd_conv
    import watch_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 2
) (
    input  logic [WIDTH-1:0]    bin,
    output logic [4*DIGITS-1:0] bcd
);

    function automatic logic [4*DIGITS-1:0] to_bcd(input logic [WIDTH-1:0] value);
        logic [4*DIGITS-1:0] acc;
        bcd_digit_t          dig;
        acc = {(4*DIGITS){1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            // Pre-correct each digit so the following shift carries into the next nibble.
            for (int d = 0; d < DIGITS; d++) begin
                dig = acc[4*d +: 4];
                if (dig >= 4'd5) begin
                    acc[4*d +: 4] = dig + 4'd3;
                end else begin
                    acc[4*d +: 4] = dig;
                end
            end
            acc = {acc[4*DIGITS-2:0], value[i]};
        end
        return acc;
    endfunction

    // Conversion is purely combinational so it adds no latency to count.
    always_comb begin
        bcd = to_bcd(bin);
    end

endmodule

// File: rtl/modn_counter.sv
// Modulo-N up/down counter for the watch time chain with cascade tc and
// registered carry. Define MODN_CNT_BCD_EN to add the count_bcd output.
module modn_counter
    import watch_pkg::*;
#(
    parameter int MODULUS   = 60,
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 0
`ifdef MODN_CNT_BCD_EN
    ,
    parameter int BCD_W     = 4 * clog10_digits(MODULUS - 1)
`endif
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             adj,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             carry
`ifdef MODN_CNT_BCD_EN
    ,
    output logic [BCD_W-1:0] count_bcd
`endif
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VAL);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("modn_counter: MODULUS must lie in 2..2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $error("modn_counter: RESET_VAL must be below MODULUS");
    end

    logic [WIDTH-1:0] count_r;
    logic             carry_r;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] load_sat_s;
    logic [WIDTH-1:0] next_count_s;
    logic             next_carry_s;
    logic             at_term_s;
    cnt_act_t         act_s;

    // Terminal value and the wrapped one-step neighbour in the current direction.
    always_comb begin
        at_term_s = 1'b0;
        step_s    = count_r;
        if (up_dn) begin
            at_term_s = (count_r == MAX_V);
            if (at_term_s) begin
                step_s = ZERO_V;
            end else begin
                step_s = count_r + ONE_V;
            end
        end else begin
            at_term_s = (count_r == ZERO_V);
            if (at_term_s) begin
                step_s = MAX_V;
            end else begin
                step_s = count_r - ONE_V;
            end
        end
    end

    // Out-of-range load data saturates to the top count value.
    always_comb begin
        load_sat_s = load_val;
        if ({1'b0, load_val} > {1'b0, MAX_V}) begin
            load_sat_s = MAX_V;
        end else begin
            load_sat_s = load_val;
        end
    end

    // Resolve the control inputs with priority load > clr > adj > en > hold.
    always_comb begin
        act_s = ACT_HOLD;
        if (load) begin
            act_s = ACT_LOAD;
        end else if (clr) begin
            act_s = ACT_CLR;
        end else if (adj) begin
            act_s = ACT_ADJ;
        end else if (en) begin
            act_s = ACT_EN;
        end else begin
            act_s = ACT_HOLD;
        end
    end

    // Next count and carry; only a tick-driven wrap raises carry, adj never does.
    always_comb begin
        next_count_s = count_r;
        next_carry_s = 1'b0;
        case (act_s)
            ACT_LOAD: begin
                next_count_s = load_sat_s;
                next_carry_s = 1'b0;
            end
            ACT_CLR: begin
                next_count_s = RST_V;
                next_carry_s = 1'b0;
            end
            ACT_ADJ: begin
                next_count_s = step_s;
                next_carry_s = 1'b0;
            end
            ACT_EN: begin
                next_count_s = step_s;
                next_carry_s = at_term_s;
            end
            ACT_HOLD: begin
                next_count_s = count_r;
                next_carry_s = 1'b0;
            end
            default: begin
                next_count_s = count_r;
                next_carry_s = 1'b0;
            end
        endcase
    end

    // Count and carry state registers.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            count_r <= RST_V;
            carry_r <= 1'b0;
        end else begin
            count_r <= next_count_s;
            carry_r <= next_carry_s;
        end
    end

    assign count = count_r;
    assign carry = carry_r;
    // Same-cycle cascade enable for the next stage; fires with the wrapping tick.
    assign tc    = (act_s == ACT_EN) & at_term_s;

`ifdef MODN_CNT_BCD_EN
    modn_bcd_conv #(
        .WIDTH  (WIDTH),
        .DIGITS (BCD_W / 4)
    ) u_bcd (
        .bin (count_r),
        .bcd (count_bcd)
    );
`endif

endmodule

// File: tb/tb_modn_counter.sv
// Randomized scoreboard bench for modn_counter: a 60-stage feeding a 24-stage
// through tc, checked against an arithmetic reference model.
module tb_modn_counter;

    localparam int M  = 60;
    localparam int MH = 24;

    logic       clk = 1'b0;
    logic       RESET;
    logic       en, up_dn, clr, load, adj, hr_clr;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc, carry;
    logic [4:0] hr_count;
    logic       hr_tc, hr_carry;
`ifdef MODN_CNT_BCD_EN
    logic [7:0] count_bcd;
    logic [7:0] hr_bcd;
`endif

    always #5 clk = ~clk;

    modn_counter #(.MODULUS(M), .WIDTH(8), .RESET_VAL(0)) dut (
        .clk(clk), .RESET(RESET), .en(en), .up_dn(up_dn), .clr(clr),
        .load(load), .load_val(load_val), .adj(adj),
        .count(count), .tc(tc), .carry(carry)
`ifdef MODN_CNT_BCD_EN
        , .count_bcd(count_bcd)
`endif
    );

    modn_counter #(.MODULUS(MH), .WIDTH(5), .RESET_VAL(0)) u_hr (
        .clk(clk), .RESET(RESET), .en(tc), .up_dn(up_dn), .clr(hr_clr),
        .load(1'b0), .load_val(5'd0), .adj(1'b0),
        .count(hr_count), .tc(hr_tc), .carry(hr_carry)
`ifdef MODN_CNT_BCD_EN
        , .count_bcd(hr_bcd)
`endif
    );

    typedef struct {
        int cnt;
        bit car;
        bit tcv;
        int hr;
        bit hr_car;
        bit hr_tcv;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_cnt, m_hr;
    bit   m_car, m_hr_car;

    function automatic int step(input int v, input int mod, input bit up);
        if (up) return (v + 1) % mod;
        else    return (v + mod - 1) % mod;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs, push the expected outputs for this cycle, advance the model.
    task automatic drive(input bit e, input bit u, input bit c, input bit l,
                         input int lv, input bit a, input bit hc);
        exp_t x;
        bit   term, t, hterm;
        en = e; up_dn = u; clr = c; load = l; load_val = lv[7:0]; adj = a; hr_clr = hc;
        term  = u ? (m_cnt == M - 1) : (m_cnt == 0);
        t     = e && !l && !c && !a && term;
        hterm = u ? (m_hr == MH - 1) : (m_hr == 0);
        x.cnt = m_cnt; x.car = m_car; x.tcv = t;
        x.hr = m_hr; x.hr_car = m_hr_car; x.hr_tcv = t && !hc && hterm;
        q.push_back(x);
        if (l) begin
            m_cnt = (lv >= M) ? M - 1 : lv; m_car = 1'b0;
        end else if (c) begin
            m_cnt = 0; m_car = 1'b0;
        end else if (a) begin
            m_cnt = step(m_cnt, M, u); m_car = 1'b0;
        end else if (e) begin
            m_car = term; m_cnt = step(m_cnt, M, u);
        end else begin
            m_car = 1'b0;
        end
        if (hc) begin
            m_hr = 0; m_hr_car = 1'b0;
        end else if (t) begin
            m_hr_car = hterm; m_hr = step(m_hr, MH, u);
        end else begin
            m_hr_car = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                check("count",    int'(count),    x.cnt);
                check("carry",    int'(carry),    int'(x.car));
                check("tc",       int'(tc),       int'(x.tcv));
                check("hr_count", int'(hr_count), x.hr);
                check("hr_carry", int'(hr_carry), int'(x.hr_car));
                check("hr_tc",    int'(hr_tc),    int'(x.hr_tcv));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit cur_up;
        RESET = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
        adj = 1'b0; hr_clr = 1'b0; load_val = 8'd0;
        m_cnt = 0; m_car = 1'b0; m_hr = 0; m_hr_car = 1'b0;
        #12;
        check("reset_count", int'(count), 0);
        check("reset_carry", int'(carry), 0);
        check("reset_hr",    int'(hr_count), 0);
        @(negedge clk) RESET = 1'b1;
        @(posedge clk); #1;

        // Up from 0 through 58, 59 and wrap to 0.
        repeat (60) drive(1, 1, 0, 0, 0, 0, 0);
        check("up_wrap_count", int'(count), 0);
        check("up_wrap_carry", int'(carry), 1);
        check("up_wrap_hr",    int'(hr_count), 1);
        drive(0, 1, 0, 0, 0, 0, 0);
        check("carry_one_cycle", int'(carry), 0);

        // Down from 0 wraps to 59; the 24-stage goes 1 -> 0 -> 23.
        drive(1, 0, 0, 0, 0, 0, 0);
        check("down_wrap_count", int'(count), 59);
        check("down_wrap_carry", int'(carry), 1);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("hr_down_wrap", int'(hr_count), 23);

        // Saturating load and load priority over clr/en.
        drive(0, 1, 0, 1, 75, 0, 0);
        check("load_sat", int'(count), 59);
        drive(1, 1, 1, 1, 12, 0, 0);
        check("load_prio_count", int'(count), 12);
        check("load_prio_carry", int'(carry), 0);

        // adj wraps without carry; en+adj gives one step.
        drive(0, 1, 0, 1, 59, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 0);
        check("adj_wrap_count", int'(count), 0);
        check("adj_wrap_carry", int'(carry), 0);
        drive(0, 1, 0, 1, 59, 0, 0);
        drive(1, 1, 0, 0, 0, 1, 0);
        check("en_adj_count", int'(count), 0);
        check("en_adj_carry", int'(carry), 0);

        // Asynchronous reset mid-cycle while count is 37.
        drive(0, 1, 0, 1, 37, 0, 0);
        en = 1'b0; load = 1'b0; adj = 1'b0; clr = 1'b0; hr_clr = 1'b0;
        #2 RESET = 1'b0;
        #1;
        check("async_reset_count", int'(count), 0);
        check("async_reset_carry", int'(carry), 0);
        m_cnt = 0; m_car = 1'b0; m_hr = 0; m_hr_car = 1'b0;
        @(negedge clk) RESET = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic.
        cur_up = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 16 == 0) cur_up = ~cur_up;
            drive(($urandom % 4) != 0, cur_up, ($urandom % 24) == 0,
                  ($urandom % 20) == 0, int'($urandom_range(0, 255)),
                  ($urandom % 12) == 0, ($urandom % 200) == 0);
        end

        // Two-stage 60x24 cascade wraps after 1440 ticks.
        drive(0, 1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 1440; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0);
            if (i == 1438) begin
                check("cascade_pre_sec", int'(count), 59);
                check("cascade_pre_hr",  int'(hr_count), 23);
            end
        end
        check("cascade_sec", int'(count), 0);
        check("cascade_hr",  int'(hr_count), 0);
        check("cascade_hr_carry", int'(hr_carry), 1);

`ifdef MODN_CNT_BCD_EN
        drive(0, 1, 1, 0, 0, 0, 0);
        for (int v = 0; v < M; v++) begin
            check("bcd", int'(count_bcd), (v / 10) * 16 + (v % 10));
            drive(1, 1, 0, 0, 0, 0, 0);
        end
`endif

        repeat (2) @(posedge clk);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
